// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct values, alucontrol codes and the aluop handed to mc_aludec.
// Build option: define MC_BNE_EN to add the BNEEX state (bne support).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_BNE_EN
    , S_BNEEX = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps (aluop, funct) to the 3-bit alucontrol. Combinational.
// Ports: aluop (add/sub/funct select), funct (instr[5:0]), alucontrol out.
module mc_aludec
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      AOP_SUB:   alucontrol = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD; // unknown funct falls back to add
        endcase
      end
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the datapath one state
// per clock, stalling FETCH/MEMRD/MEMWR on memready.
// Ports: clk, reset (async, active low), op/funct from IR, zero from ALU,
//   memready handshake; outputs are datapath enables, mux selects,
//   alucontrol, an illegal-opcode pulse and the debug state.
// Build option: define MC_BNE_EN to decode bne (op 000101) into BNEEX.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W         = 4,
  parameter int IGNORE_MEMREADY = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               memready,
  output logic               pcen,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               memread,
  output logic               iord,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   mem_rdy;
  logic   pcwrite, branch;
  logic   irwrite_c, regwrite_c, memwrite_c, memread_c, illegal_c;
`ifdef MC_BNE_EN
  logic   bne;
`endif

  assign mem_rdy = (IGNORE_MEMREADY != 0) ? 1'b1 : memready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef MC_BNE_EN
    bne        = 1'b0;
`endif
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    memread_c  = 1'b0;
    illegal_c  = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = AOP_ADD;
    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb   = 2'b01;
        irwrite_c = mem_rdy;
        pcwrite   = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11; // branch target precomputed into aluout
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord      = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1; // held for the whole stall
        iord       = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_c = 1'b1;
        regdst     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        pcsrc   = 2'b01;
        bne     = 1'b1;
        state_d = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Strobes are gated by reset directly so they drop the moment reset
  // asserts, not at the next edge: an aborted instruction never commits.
`ifdef MC_BNE_EN
  assign pcen     = reset & (pcwrite | (branch & zero) | (bne & ~zero));
`else
  assign pcen     = reset & (pcwrite | (branch & zero));
`endif
  assign irwrite  = reset & irwrite_c;
  assign regwrite = reset & regwrite_c;
  assign memwrite = reset & memwrite_c;
  assign memread  = reset & memread_c;
  assign illegal  = reset & illegal_c;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is expanded into the
// list of control steps it must walk through, and every cycle the DUT
// outputs are compared against what that step requires.
module tb_mc_controller;
  import mips_ctrl_pkg::*;

  logic       gclk = 1'b0;
  logic       grst_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, memready = 1'b0;
  logic       pcen, irwrite, regwrite, memwrite, memread, iord, regdst;
  logic       memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  always #5 gclk = ~gclk;

  mc_controller dut (
    .clk(gclk), .reset(grst_n), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen), .irwrite(irwrite),
    .regwrite(regwrite), .memwrite(memwrite), .memread(memread),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic       pcen, irwrite, regwrite, memwrite, memread, iord;
    logic       regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  typedef enum {I_LW, I_SW, I_R, I_BEQ, I_BNE, I_ADDI, I_J, I_BAD} instr_t;

  int     checks = 0, failures = 0;
  state_t seq[$];

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.pcen = pcen; o.irwrite = irwrite; o.regwrite = regwrite;
    o.memwrite = memwrite; o.memread = memread; o.iord = iord;
    o.regdst = regdst; o.memtoreg = memtoreg; o.alusrca = alusrca;
    o.alusrcb = alusrcb; o.pcsrc = pcsrc; o.alucontrol = alucontrol;
    o.illegal = illegal; o.state = state;
    return o;
  endfunction

  function automatic instr_t classify(input logic [5:0] o);
    case (o)
      6'b100011: return I_LW;
      6'b101011: return I_SW;
      6'b000000: return I_R;
      6'b000100: return I_BEQ;
      6'b001000: return I_ADDI;
      6'b000010: return I_J;
`ifdef MC_BNE_EN
      6'b000101: return I_BNE;
`endif
      default:   return I_BAD;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Steps an instruction visits, fetch included.
  task automatic load_seq(input instr_t c);
    seq.delete();
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (c)
      I_LW:   begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
      I_SW:   begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
      I_R:    begin seq.push_back(S_RTYPEEX); seq.push_back(S_RTYPEWB); end
      I_ADDI: begin seq.push_back(S_ADDIEX); seq.push_back(S_ADDIWB); end
      I_BEQ:  seq.push_back(S_BEQEX);
      I_J:    seq.push_back(S_JEX);
`ifdef MC_BNE_EN
      I_BNE:  seq.push_back(S_BNEEX);
`endif
      default: ;
    endcase
  endtask

  function automatic bit is_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  function automatic obs_t expect_out(input state_t s, input logic [5:0] o,
                                      input logic [5:0] f, input logic z,
                                      input logic mr);
    obs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    e.state = 4'(s);
    case (s)
      S_FETCH:   begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      S_DECODE:  begin e.alusrcb = 2'b11; e.illegal = (classify(o) == I_BAD); end
      S_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_MEMRD:   begin e.memread = 1; e.iord = 1; end
      S_MEMWB:   begin e.regwrite = 1; e.memtoreg = 1; end
      S_MEMWR:   begin e.memwrite = 1; e.iord = 1; end
      S_RTYPEEX: begin e.alusrca = 1; e.alucontrol = ref_alu(f); end
      S_RTYPEWB: begin e.regwrite = 1; e.regdst = 1; end
      S_BEQEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
`ifdef MC_BNE_EN
      S_BNEEX:   begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = ~z; end
`endif
      S_ADDIEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_ADDIWB:  e.regwrite = 1;
      S_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  logic [5:0] legal_f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    obs_t e;
    int   n;

    // Pin the model itself with hand-computed expectations.
    load_seq(I_LW);   check("len_lw",   seq.size(), 5);
    load_seq(I_SW);   check("len_sw",   seq.size(), 4);
    load_seq(I_R);    check("len_r",    seq.size(), 4);
    load_seq(I_ADDI); check("len_addi", seq.size(), 4);
    load_seq(I_BEQ);  check("len_beq",  seq.size(), 3);
    load_seq(I_J);    check("len_j",    seq.size(), 3);
    seq.delete();
    e = expect_out(S_RTYPEEX, 6'b0, 6'b101010, 1'b0, 1'b1);
    check("model_slt", e.alucontrol, 3'b111);
    e = expect_out(S_RTYPEEX, 6'b0, 6'b111111, 1'b0, 1'b1);
    check("model_badfunct", e.alucontrol, 3'b010);
    e = expect_out(S_MEMWB, 6'b100011, 6'b0, 1'b0, 1'b1);
    check("model_memwb", {e.regwrite, e.memtoreg}, 2'b11);

    // Reset state
    #2;
    check("reset_strobes", {pcen, irwrite, regwrite, memwrite, memread, illegal}, 6'b0);
    check("reset_state", state, 4'd0);
    @(negedge gclk);
    grst_n = 1'b1;

    // Random instruction stream
    n = 0;
    while ((n < 2000 || seq.size() != 0) && n < 20000) begin
      if (seq.size() == 0) begin
        case ($urandom_range(0, 7))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b000101;
          5: op = 6'b001000;
          6: op = 6'b000010;
          default: op = 6'($urandom);
        endcase
        funct = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
        load_seq(classify(op));
      end
      memready = ($urandom_range(0, 3) != 0);
      zero     = 1'($urandom_range(0, 1));
      #1;
      e = expect_out(seq[0], op, funct, zero, memready);
      check($sformatf("cycle%0d_op%b", n, op), dut_obs(), e);
      if (!(is_wait(seq[0]) && !memready)) void'(seq.pop_front());
      n++;
      @(negedge gclk);
    end
    check("stream_drained", seq.size(), 0);

    // FETCH stall then sw held in MEMWR, aborted by reset
    op = 6'b101011; funct = 6'b0; memready = 1'b0;
    repeat (3) begin
      #1;
      check("stall_fetch", {irwrite, pcen}, 2'b00);
      check("stall_state", state, 4'd0);
      @(negedge gclk);
    end
    memready = 1'b1;
    #1 check("fetch_go", {irwrite, pcen}, 2'b11);
    @(negedge gclk);
    #1 check("decode_state", state, 4'd1);
    @(negedge gclk);
    #1 check("memadr_state", state, 4'd2);
    @(negedge gclk);
    memready = 1'b0;
    #1 check("memwr_hold", {memwrite, iord, state}, {2'b11, 4'd5});
    @(negedge gclk);
    #1 check("memwr_hold2", memwrite, 1'b1);
    #2 grst_n = 1'b0;
    #1 check("abort_memwrite", {memwrite, state}, {1'b0, 4'd0});
    @(negedge gclk);
    grst_n = 1'b1;
    memready = 1'b1;
    #1 check("refetch", {iord, memread, irwrite, state}, {3'b011, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
